// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Groups the request/result signals of the sequential divider.
//   master : drives start/dividend/divisor, observes busy/done/results
//   slave  : the divider side
//   start       - request pulse, accepted in IDLE or DONE
//   dividend    - unsigned dividend, WIDTH bits
//   divisor     - unsigned divisor, WIDTH bits
//   busy        - high while iterating
//   done        - one-cycle result strobe
//   quotient    - registered quotient, held until the next result
//   remainder   - registered remainder, held until the next result
//   div_by_zero - set with done when the divisor was zero
interface seq_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Latency WIDTH+1 cycles from accepted start to done (1 cycle when
//   the divisor is zero).
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_divider_if slave: start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    // The partial remainder is always below the divisor after an
    // iteration, so the top bit of the WIDTH+1 trial value never needs
    // storing; only the shifted trial operand is WIDTH+1 bits wide.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // Shared iteration datapath
    always_comb begin
        accept    = bus.start && (state_q == IDLE || state_q == DONE);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        r_shift   = {r_q, q_q[WIDTH-1]};
        // Trial subtraction as add of the inverted divisor with carry-in.
        diff      = r_shift + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
        if (!diff[WIDTH]) begin
            r_next = diff[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        q_d    = q_q;
        d_d    = d_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            q_d   = bus.dividend;
            d_d   = bus.divisor;
            r_d   = '0;
            cnt_d = '0;
            if (bus.divisor == '0) begin
                quot_d = '1;
                rem_d  = bus.dividend;
                dbz_d  = 1'b1;
            end
        end else if (state_q == CALC) begin
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
                quot_d = q_next;
                rem_d  = r_next;
                dbz_d  = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.busy        = (state_q == CALC);
        bus.done        = (state_q == DONE);
        bus.quotient    = quot_q;
        bus.remainder   = rem_q;
        bus.div_by_zero = dbz_q;
    end
endmodule
